// File: rtl/mul_bus_master.sv
// rtl/mul_bus_master.sv - bus master driving a strobed multiplier peripheral: operand writes, status polling, result reads
module mul_bus_master #(
    parameter int STROBE_CYCLES = 2,
    parameter int MIN_WAIT      = 4,
    parameter int POLL_LIMIT    = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [23:0] cmd_a1,
    input  logic [23:0] cmd_a2,
    output logic [15:0] saddress,
    output logic        srd,
    output logic        swr,
    output logic [31:0] sdata_out,
    input  logic [31:0] sdata_in,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_w,
    output logic [23:0] res_ones,
    output logic        res_ovf,
    output logic        res_err,
    output logic [15:0] op_count
);

    localparam logic [15:0] ADDR_A1   = 16'h037F;
    localparam logic [15:0] ADDR_A2   = 16'h0388;
    localparam logic [15:0] ADDR_CTRL = 16'h03A0;
    localparam logic [15:0] ADDR_W    = 16'h0390;
    localparam logic [15:0] ADDR_L    = 16'h0398;

    localparam logic [3:0]  STRB_LAST = 4'(STROBE_CYCLES - 1);
    localparam logic [15:0] WAIT_LAST = 16'(MIN_WAIT - 1);
    localparam logic [7:0]  POLL_LAST = 8'(POLL_LIMIT - 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_WR_A1, ST_WR_A2, ST_WR_START, ST_WAIT,
        ST_POLL, ST_RD_W, ST_RD_L, ST_RESULT
    } state_t;

    // Every peripheral access walks SETUP -> STROBE (STROBE_CYCLES) -> HOLD.
    typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_HOLD} phase_t;

    state_t      state;
    phase_t      phase;
    logic [3:0]  strb_cnt;
    logic [15:0] wait_cnt;
    logic [7:0]  poll_cnt;
    logic [31:0] rd_data;
    logic [23:0] a2_q;
    logic        is_read;

    assign is_read   = (state == ST_POLL) || (state == ST_RD_W) || (state == ST_RD_L);
    // Held low while reset is asserted even though the state already reads IDLE.
    assign cmd_ready = (state == ST_IDLE) && !reset;

    // Command sequencer and bus access engine; all bus outputs are registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            phase     <= PH_SETUP;
            strb_cnt  <= '0;
            wait_cnt  <= '0;
            poll_cnt  <= '0;
            rd_data   <= '0;
            a2_q      <= '0;
            saddress  <= '0;
            srd       <= 1'b0;
            swr       <= 1'b0;
            sdata_out <= '0;
            res_valid <= 1'b0;
            res_w     <= '0;
            res_ones  <= '0;
            res_ovf   <= 1'b0;
            res_err   <= 1'b0;
            op_count  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        a2_q      <= cmd_a2;
                        res_err   <= 1'b0;
                        state     <= ST_WR_A1;
                        phase     <= PH_SETUP;
                        saddress  <= ADDR_A1;
                        sdata_out <= {8'h00, cmd_a1};
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state     <= ST_POLL;
                        phase     <= PH_SETUP;
                        poll_cnt  <= '0;
                        saddress  <= ADDR_CTRL;
                        sdata_out <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        op_count  <= op_count + 16'd1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    case (phase)
                        PH_SETUP: begin
                            phase    <= PH_STROBE;
                            strb_cnt <= '0;
                            srd      <= is_read;
                            swr      <= !is_read;
                        end
                        PH_STROBE: begin
                            if (strb_cnt == STRB_LAST) begin
                                srd   <= 1'b0;
                                swr   <= 1'b0;
                                phase <= PH_HOLD;
                                if (is_read) rd_data <= sdata_in;
                            end else begin
                                strb_cnt <= strb_cnt + 4'd1;
                            end
                        end
                        default: begin
                            // HOLD done: address may now change for the next access.
                            phase <= PH_SETUP;
                            case (state)
                                ST_WR_A1: begin
                                    state     <= ST_WR_A2;
                                    saddress  <= ADDR_A2;
                                    sdata_out <= {8'h00, a2_q};
                                end
                                ST_WR_A2: begin
                                    state     <= ST_WR_START;
                                    saddress  <= ADDR_CTRL;
                                    sdata_out <= '0;
                                end
                                ST_WR_START: begin
                                    state    <= ST_WAIT;
                                    wait_cnt <= '0;
                                end
                                ST_POLL: begin
                                    if (rd_data[1]) begin
                                        res_ovf  <= !rd_data[0];
                                        state    <= ST_RD_W;
                                        saddress <= ADDR_W;
                                    end else if (poll_cnt == POLL_LAST) begin
                                        res_err   <= 1'b1;
                                        res_w     <= '0;
                                        res_ones  <= '0;
                                        res_ovf   <= 1'b0;
                                        res_valid <= 1'b1;
                                        state     <= ST_RESULT;
                                    end else begin
                                        poll_cnt <= poll_cnt + 8'd1;
                                    end
                                end
                                ST_RD_W: begin
                                    res_w    <= rd_data;
                                    state    <= ST_RD_L;
                                    saddress <= ADDR_L;
                                end
                                ST_RD_L: begin
                                    res_ones  <= rd_data[23:0];
                                    res_valid <= 1'b1;
                                    state     <= ST_RESULT;
                                end
                                default: state <= ST_IDLE;
                            endcase
                        end
                    endcase
                end
            endcase
        end
    end

endmodule

// File: doc/mul_bus_master.md
MUL_BUS_MASTER -- requirements
Module: mul_bus_master

Interface
REQ-001 Parameters SHALL be: STROBE_CYCLES, default 2, width of each srd/swr pulse in clk cycles (legal 1..15); MIN_WAIT, default 4, clk cycles between end of start write and first status poll; POLL_LIMIT, default 64, max status reads before timeout (legal 1..255).
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 cmd_valid  in  1  host presents an operand pair.
REQ-005 cmd_ready  out  1  block accepts a command this cycle.
REQ-006 cmd_a1, cmd_a2  in  24 each  operands.
REQ-007 saddress  out  16  peripheral register address.
REQ-008 srd, swr  out  1 each  read/write strobes to peripheral, active-high.
REQ-009 sdata_out  out  32  write data to peripheral sdata_in.
REQ-010 sdata_in  in  32  read data from peripheral sdata_out.
REQ-011 res_valid  out  1  result available; res_ready  in  1  host accepts it.
REQ-012 res_w  out  32 product; res_ones  out  24 ones count; res_ovf  out  1 product exceeded 32 bits; res_err  out  1 poll timeout.
REQ-013 op_count  out  16  completed commands, including timeouts.

Function
REQ-014 Peripheral map SHALL be: 0x037F A1 write; 0x0388 A2 write; 0x03A0 start write / status read (bit1 ready, bit0 valid); 0x0390 W read; 0x0398 L read.
REQ-015 Every bus access SHALL be SETUP (1 cycle, address/data driven, strobes low), STROBE (STROBE_CYCLES cycles, one strobe high), HOLD (1 cycle, strobes low, address held).
REQ-016 srd and swr SHALL never be high in the same cycle; the strobe rises only after saddress has been stable for one cycle.
REQ-017 Read data SHALL be captured from sdata_in on the last STROBE cycle of a read.
REQ-018 States: IDLE, WR_A1, WR_A2, WR_START, WAIT, POLL, RD_W, RD_L, RESULT.
REQ-019 IDLE: cmd_ready=1; on cmd_valid&cmd_ready latch operands, go WR_A1; cmd_ready=0 in all other states.
REQ-020 WR_A1 writes {8'h0,a1} to 0x037F; WR_A2 writes {8'h0,a2} to 0x0388; WR_START writes 32'h0 to 0x03A0; then WAIT.
REQ-021 WAIT counts MIN_WAIT cycles with strobes low, then POLL.
REQ-022 POLL reads 0x03A0; bit1=1 -> latch res_ovf = ~bit0, go RD_W; bit1=0 -> increment poll count, re-poll immediately (next SETUP).
REQ-023 Poll count reaching POLL_LIMIT with bit1 still 0 SHALL set res_err=1, res_w=0, res_ones=0, res_ovf=0, go RESULT.
REQ-024 RD_W reads 0x0390 into res_w; RD_L reads 0x0398, res_ones = sdata_in[23:0]; then RESULT.
REQ-025 RESULT: res_valid=1, outputs stable until res_valid&res_ready; on that cycle op_count increments (wraps 0xFFFF->0x0000), go IDLE.
REQ-026 A cmd_valid arriving in RESULT with res_ready high in the same cycle SHALL NOT be accepted until the following IDLE cycle.
REQ-027 Minimum command-to-res_valid latency, STROBE_CYCLES=2, ready on first poll: 3 writes x4 + MIN_WAIT + 3 reads x4 = 28 cycles.
REQ-028 res_err cleared when the next command is accepted.

Reset
REQ-029 reset high SHALL immediately force IDLE, srd=0, swr=0, saddress=0, sdata_out=0, res_valid=0, res_w=0, res_ones=0, res_ovf=0, res_err=0, op_count=0, cmd_ready=0 while reset high, 1 in first cycle after release.
REQ-030 Reset asserted mid-access SHALL drop the strobe in the same instant; no partial access completes after release.

Verification
REQ-031 cmd a1=3, a2=5, peripheral model ready after 2 polls -> writes 0x037F=3, 0x0388=5, 0x03A0=0 in order; res_w=15, res_ones=4, res_ovf=0, res_err=0, op_count=1.
REQ-032 a1=a2=0xFFFFFF, status returns bit0=0 -> res_ovf=1, res_w equals model low 32 bits.
REQ-033 Model never sets ready -> exactly 64 reads of 0x03A0, then res_valid with res_err=1, res_w=0; op_count increments.
REQ-034 Hold res_ready=0 for 10 cycles in RESULT -> res_valid and result fields unchanged; cmd_valid ignored until handshake and return to IDLE.
REQ-035 Assert reset during STROBE of WR_A2 -> swr drops asynchronously, all outputs at reset values; next command runs full sequence from WR_A1.
REQ-036 Bus checker, all tests: strobes never overlap, each strobe exactly STROBE_CYCLES wide, address stable from SETUP through HOLD.
